// File: rtl/ghr_pkg.sv
// Shared types and helpers for the global-history-register controller.
package ghr_pkg;

    // Default history width and checkpoint depth.
    localparam int GHR_W      = 32;
    localparam int GHR_N_CKPT = 8;

    // Widest history the shift helper handles; W must not exceed this.
    localparam int GHR_MAX_W  = 64;

    // RECOVER is a one-cycle bubble after a mispredict or flush.
    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } ghr_state_t;

    // Shift a new outcome into bit 0. Callers zero-extend their history to
    // GHR_MAX_W and truncate the result back to their own width.
    function automatic logic [GHR_MAX_W-1:0] ghr_shift(
        input logic [GHR_MAX_W-1:0] hist,
        input logic                 bit_in
    );
        return {hist[GHR_MAX_W-2:0], bit_in};
    endfunction

endpackage

// File: rtl/ghr_ctrl_if.sv
// Predictor / resolve / retire / history bus of the GHR controller.
interface ghr_ctrl_if #(
    parameter int W      = ghr_pkg::GHR_W,
    parameter int N_CKPT = ghr_pkg::GHR_N_CKPT
);
    localparam int IW = $clog2(N_CKPT);

    logic          pred_valid;
    logic          pred_taken;
    logic          pred_ready;
    logic [IW-1:0] pred_id;
    logic          resolve_valid;
    logic [IW-1:0] resolve_id;
    logic          resolve_taken;
    logic          retire_valid;
    logic          retire_taken;
    logic          flush;
    logic [W-1:0]  spec_hist;
    logic [W-1:0]  arch_hist;
    logic [IW:0]   occupancy;
    logic          recovering;

    // Pipeline side: fetch, branch unit, ROB and the predictor tables.
    modport master (
        output pred_valid, pred_taken, resolve_valid, resolve_id, resolve_taken,
               retire_valid, retire_taken, flush,
        input  pred_ready, pred_id, spec_hist, arch_hist, occupancy, recovering
    );

    // Controller side.
    modport slave (
        input  pred_valid, pred_taken, resolve_valid, resolve_id, resolve_taken,
               retire_valid, retire_taken, flush,
        output pred_ready, pred_id, spec_hist, arch_hist, occupancy, recovering
    );
endinterface

// File: rtl/dffen.sv
// Enabled register with synchronous active-high reset to zero.
module dffen #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // Load on enable; reset has priority.
    always_ff @(posedge clk) begin
        if (reset)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/ghr_ckpt_ring.sv
// Checkpoint storage: one write port at the ring tail, one asynchronous read
// port so a mispredict can restore history in the same cycle it arrives.
module ghr_ckpt_ring #(
    parameter int W      = 32,
    parameter int N_CKPT = 8
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [$clog2(N_CKPT)-1:0] waddr,
    input  logic [W-1:0]              wdata,
    input  logic [$clog2(N_CKPT)-1:0] raddr,
    output logic [W-1:0]              rdata
);
    logic [W-1:0] mem [N_CKPT];

    // Contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ghr_ctrl.sv
// Speculative / architectural global-history controller with a ring of
// per-branch checkpoints for single-cycle mispredict recovery.
module ghr_ctrl
    import ghr_pkg::*;
#(
    parameter int W      = GHR_W,
    parameter int N_CKPT = GHR_N_CKPT
) (
    input  logic       clk,
    input  logic       reset,
    ghr_ctrl_if.slave  bus
);
    localparam int IW = $clog2(N_CKPT);
    localparam int CW = IW + 1;

    ghr_state_t    state_reg, state_next;
    logic [IW-1:0] head_reg, head_next;
    logic [IW-1:0] tail_reg, tail_next;
    logic [CW-1:0] count_reg, count_next;

    logic [W-1:0]  spec_q, spec_next, arch_q;
    logic          spec_en;
    logic [W-1:0]  ckpt_rd;
    logic [W-1:0]  spec_pred_sh, arch_ret_sh, ckpt_res_sh;
    logic [IW-1:0] res_dist;
    logic          pred_fire;

    // Ready never depends on pred_valid, so fetch sees no combinational loop.
    assign bus.pred_ready = (state_reg == RUN) && (count_reg != CW'(N_CKPT))
                          && !bus.resolve_valid && !bus.flush;
    assign pred_fire      = bus.pred_valid && bus.pred_ready;

    assign spec_pred_sh = W'(ghr_shift(GHR_MAX_W'(spec_q), bus.pred_taken));
    assign arch_ret_sh  = W'(ghr_shift(GHR_MAX_W'(arch_q), bus.retire_taken));
    assign ckpt_res_sh  = W'(ghr_shift(GHR_MAX_W'(ckpt_rd), bus.resolve_taken));

    // Distance of the mispredicted branch from the oldest entry, mod N_CKPT.
    assign res_dist = bus.resolve_id - head_reg;

    ghr_ckpt_ring #(
        .W      (W),
        .N_CKPT (N_CKPT)
    ) u_ring (
        .clk   (clk),
        .we    (pred_fire),
        .waddr (tail_reg),
        .wdata (spec_q),
        .raddr (bus.resolve_id),
        .rdata (ckpt_rd)
    );

    dffen #(.WIDTH(W)) u_spec (
        .clk   (clk),
        .reset (reset),
        .en    (spec_en),
        .d     (spec_next),
        .q     (spec_q)
    );

    dffen #(.WIDTH(W)) u_arch (
        .clk   (clk),
        .reset (reset),
        .en    (bus.retire_valid),
        .d     (arch_ret_sh),
        .q     (arch_q)
    );

    // Event priority: flush, then mispredict, then prediction; retire always applies.
    always_comb begin
        state_next = RUN;
        head_next  = head_reg + IW'(bus.retire_valid);
        tail_next  = tail_reg;
        count_next = count_reg - CW'(bus.retire_valid);
        spec_next  = spec_q;
        spec_en    = 1'b0;
        if (bus.flush) begin
            spec_next  = bus.retire_valid ? arch_ret_sh : arch_q;
            spec_en    = 1'b1;
            head_next  = '0;
            tail_next  = '0;
            count_next = '0;
            state_next = RECOVER;
        end else if (bus.resolve_valid) begin
            spec_next  = ckpt_res_sh;
            spec_en    = 1'b1;
            tail_next  = bus.resolve_id + IW'(1);
            count_next = {1'b0, res_dist} + CW'(1) - CW'(bus.retire_valid);
            state_next = RECOVER;
        end else if (pred_fire) begin
            spec_next  = spec_pred_sh;
            spec_en    = 1'b1;
            tail_next  = tail_reg + IW'(1);
            count_next = count_reg + CW'(1) - CW'(bus.retire_valid);
        end
    end

    // Ring pointers, occupancy and FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    assign bus.pred_id    = tail_reg;
    assign bus.occupancy  = count_reg;
    assign bus.spec_hist  = spec_q;
    assign bus.arch_hist  = arch_q;
    assign bus.recovering = (state_reg == RECOVER);
endmodule

// File: tb/tb_ghr_ctrl.sv
// Scoreboard bench for ghr_ctrl: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_ghr_ctrl;
    localparam int W = 32;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          cyc;
        string       tag;
        logic [31:0] spec;
        logic [31:0] arch;
        int          occ;
        int          pid;
        bit          rec;
        bit          rdy;
    } exp_t;

    exp_t exq[$];
    int   idq[$];

    ghr_ctrl_if #(.W(W), .N_CKPT(N)) bus();

    ghr_ctrl #(.W(W), .N_CKPT(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: accepted predictions, protocol rules and queued snapshots.
    exp_t mon_x;
    int   mon_id;
    int   mon_d;
    always @(negedge clk) begin
        if (!reset && bus.pred_valid && bus.pred_ready) begin
            if (idq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL accept_unexpected: accepted with id %0d, no acceptance required", bus.pred_id);
            end else begin
                mon_id = idq.pop_front();
                chk("accept_id", 64'(bus.pred_id), 64'(mon_id));
            end
        end
        if (!reset && bus.retire_valid) begin
            checks++;
            if (bus.occupancy == 0) begin
                errors++;
                $display("FAIL retire_empty: retire with occupancy %0d, required nonzero", bus.occupancy);
            end
        end
        if (!reset && bus.resolve_valid && !bus.flush) begin
            mon_d = int'(3'(bus.pred_id - bus.resolve_id));
            if (mon_d == 0) mon_d = N;
            checks++;
            if (mon_d > int'(bus.occupancy)) begin
                errors++;
                $display("FAIL resolve_range: id %0d distance %0d, required <= %0d", bus.resolve_id, mon_d, bus.occupancy);
            end
        end
        while (exq.size() > 0 && exq[0].cyc <= cyc) begin
            mon_x = exq.pop_front();
            if (mon_x.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s_stale: checked at cycle %0d, required cycle %0d", mon_x.tag, cyc, mon_x.cyc);
            end else begin
                $display("cyc %0d %s spec=0x%0h arch=0x%0h occ=%0d id=%0d rec=%0b rdy=%0b",
                         cyc, mon_x.tag, bus.spec_hist, bus.arch_hist, bus.occupancy,
                         bus.pred_id, bus.recovering, bus.pred_ready);
                chk({mon_x.tag, "_spec"}, 64'(bus.spec_hist),  64'(mon_x.spec));
                chk({mon_x.tag, "_arch"}, 64'(bus.arch_hist),  64'(mon_x.arch));
                chk({mon_x.tag, "_occ"},  64'(bus.occupancy),  64'(mon_x.occ));
                chk({mon_x.tag, "_id"},   64'(bus.pred_id),    64'(mon_x.pid));
                chk({mon_x.tag, "_rec"},  64'(bus.recovering), 64'(mon_x.rec));
                chk({mon_x.tag, "_rdy"},  64'(bus.pred_ready), 64'(mon_x.rdy));
            end
        end
    end

    task automatic drive(input bit pv, input bit pt, input bit rv, input int rid,
                         input bit rt, input bit tv, input bit tt, input bit fl);
        bus.pred_valid    = pv;
        bus.pred_taken    = pt;
        bus.resolve_valid = rv;
        bus.resolve_id    = 3'(rid);
        bus.resolve_taken = rt;
        bus.retire_valid  = tv;
        bus.retire_taken  = tt;
        bus.flush         = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ex(input string tag, input logic [31:0] s, input logic [31:0] a,
                      input int occ, input int pid, input bit rec, input bit rdy);
        exp_t e;
        e.cyc = cyc; e.tag = tag; e.spec = s; e.arch = a;
        e.occ = occ; e.pid = pid; e.rec = rec; e.rdy = rdy;
        exq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Prediction expected to be accepted with the given tag.
    task automatic pred(input bit t, input int id);
        drive(1, t, 0, 0, 0, 0, 0, 0);
        idq.push_back(id);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        tick();
        reset_dut();

        // Four predictions T,N,T,T
        pred(1, 0); ex("t1_rst", 32'h0, 0, 0, 0, 0, 1); tick();
        pred(0, 1); ex("t1_p1", 32'h1, 0, 1, 1, 0, 1); tick();
        pred(1, 2); ex("t1_p2", 32'h2, 0, 2, 2, 0, 1); tick();
        pred(1, 3); ex("t1_p3", 32'h5, 0, 3, 3, 0, 1); tick();
        idle();     ex("t1_end", 32'hB, 0, 4, 4, 0, 1); tick();

        // Fill the ring, then retire alongside blocked and accepted predictions
        pred(0, 4); ex("t2_p4", 32'hB, 0, 4, 4, 0, 1); tick();
        pred(0, 5); ex("t2_p5", 32'h16, 0, 5, 5, 0, 1); tick();
        pred(0, 6); ex("t2_p6", 32'h2C, 0, 6, 6, 0, 1); tick();
        pred(0, 7); ex("t2_p7", 32'h58, 0, 7, 7, 0, 1); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0); ex("t2_full", 32'hB0, 0, 8, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 1, 1, 0); ex("t2_full_ret", 32'hB0, 0, 8, 0, 0, 0); tick();
        pred(1, 0); ex("t2_after_ret", 32'hB0, 1, 7, 0, 0, 1); tick();
        drive(1, 0, 0, 0, 0, 1, 1, 0); ex("t2_full2", 32'h161, 1, 8, 1, 0, 0); tick();
        pred(0, 1); bus.retire_valid = 1'b1; bus.retire_taken = 1'b0;
        ex("t2_ret_pred", 32'h161, 3, 7, 1, 0, 1); tick();
        idle(); ex("t2_end", 32'h2C2, 6, 7, 2, 0, 1); tick();

        // Mispredict recovery
        reset_dut();
        pred(1, 0); ex("t3_p0", 32'h0, 0, 0, 0, 0, 1); tick();
        pred(1, 1); ex("t3_p1", 32'h1, 0, 1, 1, 0, 1); tick();
        pred(1, 2); ex("t3_p2", 32'h3, 0, 2, 2, 0, 1); tick();
        drive(1, 1, 1, 1, 0, 0, 0, 0); ex("t3_res", 32'h7, 0, 3, 3, 0, 0); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 0); ex("t3_recover", 32'h2, 0, 2, 2, 1, 0); tick();
        pred(1, 2); ex("t3_run", 32'h2, 0, 2, 2, 0, 1); tick();

        // Resolve, prediction and retire together
        drive(1, 1, 1, 1, 1, 1, 1, 0); ex("t4_all", 32'h5, 0, 3, 3, 0, 0); tick();
        idle(); ex("t4_recover", 32'h3, 1, 1, 2, 1, 0); tick();
        idle(); ex("t4_run", 32'h3, 1, 1, 2, 0, 1); tick();

        // Retires then flush; flush with same-cycle retire
        reset_dut();
        for (int k = 0; k < 8; k++) begin
            pred(1, k); ex("t5_fill", (32'h1 << k) - 32'h1, 0, k, k, 0, 1); tick();
        end
        drive(0, 0, 0, 0, 0, 1, 1, 0); ex("t5_ret0", 32'hFF, 0, 8, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 1, 0, 0); ex("t5_ret1", 32'hFF, 1, 7, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 1, 1, 0); ex("t5_ret2", 32'hFF, 2, 6, 0, 0, 1); tick();
        drive(1, 1, 0, 0, 0, 0, 0, 1); ex("t5_flush", 32'hFF, 5, 5, 0, 0, 0); tick();
        idle(); ex("t5_recover", 32'h5, 5, 0, 0, 1, 0); tick();
        pred(0, 0); ex("t5_run", 32'h5, 5, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 1, 1, 1); ex("t5_flush_ret", 32'hA, 5, 1, 1, 0, 0); tick();
        idle(); ex("t5_recover2", 32'hB, 32'hB, 0, 0, 1, 0); tick();

        // Resolve during RECOVER, then reset during RECOVER
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            pred(1, k); ex("t6_fill", (32'h1 << k) - 32'h1, 0, k, k, 0, 1); tick();
        end
        drive(0, 0, 1, 2, 0, 0, 0, 0); ex("t6_res", 32'hF, 0, 4, 4, 0, 0); tick();
        drive(0, 0, 1, 1, 1, 0, 0, 0); ex("t6_res_in_rec", 32'h6, 0, 3, 3, 1, 0); tick();
        idle(); ex("t6_rec_again", 32'h3, 0, 2, 2, 1, 0); tick();
        pred(1, 2); ex("t6_run", 32'h3, 0, 2, 2, 0, 1); tick();
        drive(0, 0, 1, 2, 0, 0, 0, 0); ex("t6_res2", 32'h7, 0, 3, 3, 0, 0); tick();
        reset = 1'b1;
        drive(1, 1, 0, 0, 0, 1, 1, 0); ex("t6_rst_in_rec", 32'h6, 0, 3, 3, 1, 0); tick();
        reset = 1'b0;
        idle(); ex("t6_after_rst", 32'h0, 0, 0, 0, 0, 1); tick();

        tick();
        tick();
        chk("exp_queue_drained", 64'(exq.size()), 64'd0);
        chk("id_queue_drained", 64'(idq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
